// File: rtl/vm_pkg.sv
// Shared types for the multi-product vending machine: FSM states, coin codes,
// and coin code to half-unit conversion.
package vm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_TWO  = 2'b11;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_HALF: return 3'd1;
      COIN_ONE:  return 3'd2;
      COIN_TWO:  return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_credit_acc.sv
// Credit register: saturating-free add with MAX_CREDIT guard, price subtract,
// and decrement-by-one for serial change return.
module vm_credit_acc #(
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_add_en,
  input  logic [2:0]          i_coin_val,
  input  logic                i_sub_en,
  input  logic [CREDIT_W-1:0] i_price,
  input  logic                i_dec_en,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [CREDIT_W-1:0] o_eff,
  output logic                o_coin_ok
);

  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_nxt;

  // One extra bit so a coin on top of a near-full credit cannot wrap.
  assign w_sum     = {1'b0, r_credit} + {{(CREDIT_W-2){1'b0}}, i_coin_val};
  assign o_coin_ok = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign o_eff     = (i_add_en && o_coin_ok) ? w_sum[CREDIT_W-1:0] : r_credit;
  assign o_credit  = r_credit;

  always_comb begin
    w_nxt = o_eff;
    if (i_dec_en)
      w_nxt = (r_credit != '0) ? r_credit - CREDIT_W'(1) : '0;
    else if (i_sub_en && (o_eff >= i_price))
      w_nxt = o_eff - i_price;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_credit <= '0;
    else     r_credit <= w_nxt;
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin intake, per-item price selection,
// vend pulse and serial change/refund return.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                          N_ITEMS     = 4,
  parameter int                          CREDIT_W    = 6,
  parameter int                          MAX_CREDIT  = 40,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {6'd10, 6'd3, 6'd6, 6'd4},
  parameter bit                          AUTO_VEND   = 1'b0,
  localparam int                         ID_W        = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coins,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                cancel,
  output logic                sell,
  output logic [ID_W-1:0]     sell_id,
  output logic                change,
  output logic                coin_reject,
  output logic                sel_deny,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state
);

  state_e              r_state, w_nxt_state;
  logic                r_sell, r_change, r_reject, r_deny;
  logic [ID_W-1:0]     r_sell_id;
  logic                w_sell_nxt, w_change_nxt, w_reject_nxt, w_deny_nxt;
  logic [ID_W-1:0]     w_sell_id_nxt;

  logic [CREDIT_W-1:0] w_prices [N_ITEMS];
  logic [CREDIT_W-1:0] w_price, w_eff, w_credit;
  logic [ID_W-1:0]     w_idx;
  logic                w_id_ok, w_active, w_coin, w_coin_ok, w_coin_take;
  logic                w_vend, w_refund, w_dec;

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_price
    assign w_prices[g] = ITEM_PRICES[g*CREDIT_W +: CREDIT_W];
  end

  assign w_id_ok     = (32'(sel_id) < N_ITEMS);
  assign w_idx       = (AUTO_VEND || !w_id_ok) ? '0 : sel_id;
  assign w_price     = w_prices[w_idx];
  assign w_active    = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign w_coin      = (coins != COIN_NONE);
  assign w_coin_take = w_active && w_coin && w_coin_ok;
  assign w_refund    = w_active && cancel;
  assign w_dec       = (r_state == ST_CHANGE);
  // Vend decision uses the effective credit so a coin and selection in the
  // same cycle can complete a purchase.
  assign w_vend      = w_active && !cancel && (w_eff >= w_price) &&
                       (AUTO_VEND || (sel_valid && w_id_ok));

  vm_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_add_en   (w_active),
    .i_coin_val (coin_value(coins)),
    .i_sub_en   (w_vend),
    .i_price    (w_price),
    .i_dec_en   (w_dec),
    .o_credit   (w_credit),
    .o_eff      (w_eff),
    .o_coin_ok  (w_coin_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sell    <= 1'b0;
      r_sell_id <= '0;
      r_change  <= 1'b0;
      r_reject  <= 1'b0;
      r_deny    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_sell    <= w_sell_nxt;
      r_sell_id <= w_sell_id_nxt;
      r_change  <= w_change_nxt;
      r_reject  <= w_reject_nxt;
      r_deny    <= w_deny_nxt;
    end
  end

  always_comb begin
    w_nxt_state = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        w_nxt_state = w_coin_take ? ST_ACCUM : r_state;
        if (w_refund)    w_nxt_state = (w_eff != '0) ? ST_CHANGE : ST_IDLE;
        else if (w_vend) w_nxt_state = ST_VEND;
      end
      ST_VEND:   w_nxt_state = (w_credit != '0) ? ST_CHANGE : ST_IDLE;
      ST_CHANGE: w_nxt_state = (w_credit == '0) ? ST_IDLE : ST_CHANGE;
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sell_nxt    = w_vend;
    w_sell_id_nxt = w_vend ? w_idx : r_sell_id;
    w_change_nxt  = w_dec && (w_credit != '0);
    w_reject_nxt  = w_coin && !w_coin_take;
    w_deny_nxt    = sel_valid &&
                    (!w_active || (!AUTO_VEND && !cancel && !w_vend));
  end

  assign sell        = r_sell;
  assign sell_id     = r_sell_id;
  assign change      = r_change;
  assign coin_reject = r_reject;
  assign sel_deny    = r_deny;
  assign credit      = w_credit;
  assign state       = r_state;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: one instance in selection mode, one in
// auto-vend mode; vends are checked against a queue of expected item ids.
module tb_vending_machine_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // selection-mode instance
  logic [1:0] m_coins = 2'b00;
  logic       m_selv = 1'b0, m_cancel = 1'b0;
  logic [1:0] m_selid = 2'd0;
  logic       m_sell, m_change, m_rej, m_deny;
  logic [1:0] m_sell_id;
  logic [5:0] m_credit;
  logic [2:0] m_state;

  // auto-vend instance
  logic [1:0] a_coins = 2'b00;
  logic       a_selv = 1'b0, a_cancel = 1'b0;
  logic [1:0] a_selid = 2'd0;
  logic       a_sell, a_change, a_rej, a_deny;
  logic [1:0] a_sell_id;
  logic [5:0] a_credit;
  logic [2:0] a_state;

  int exp_m_q[$];
  int exp_a_q[$];

  vending_machine_multi dut_m (
    .clk(clk), .rst(rst), .coins(m_coins), .sel_valid(m_selv), .sel_id(m_selid),
    .cancel(m_cancel), .sell(m_sell), .sell_id(m_sell_id), .change(m_change),
    .coin_reject(m_rej), .sel_deny(m_deny), .credit(m_credit), .state(m_state)
  );

  vending_machine_multi #(.AUTO_VEND(1'b1)) dut_a (
    .clk(clk), .rst(rst), .coins(a_coins), .sel_valid(a_selv), .sel_id(a_selid),
    .cancel(a_cancel), .sell(a_sell), .sell_id(a_sell_id), .change(a_change),
    .coin_reject(a_rej), .sel_deny(a_deny), .credit(a_credit), .state(a_state)
  );

  // scoreboard: every vend pulse must match the next expected item
  always @(negedge clk) begin
    if (m_sell === 1'b1) begin
      n_cmp++;
      if (exp_m_q.size() == 0) begin
        n_bad++; $display("FAIL sb_m unexpected vend: got id %0d, none expected", m_sell_id);
      end else begin
        int e;
        e = exp_m_q.pop_front();
        if (int'(m_sell_id) !== e) begin
          n_bad++; $display("FAIL sb_m sell_id: got %0d expected %0d", m_sell_id, e);
        end
      end
    end
    if (a_sell === 1'b1) begin
      n_cmp++;
      if (exp_a_q.size() == 0) begin
        n_bad++; $display("FAIL sb_a unexpected vend: got id %0d, none expected", a_sell_id);
      end else begin
        int e;
        e = exp_a_q.pop_front();
        if (int'(a_sell_id) !== e) begin
          n_bad++; $display("FAIL sb_a sell_id: got %0d expected %0d", a_sell_id, e);
        end
      end
    end
  end

  task automatic drv_m(input logic [1:0] c, input logic sv, input logic [1:0] sid, input logic can);
    m_coins = c; m_selv = sv; m_selid = sid; m_cancel = can;
    @(negedge clk);
    m_coins = 2'b00; m_selv = 1'b0; m_selid = 2'd0; m_cancel = 1'b0;
  endtask

  task automatic drv_a(input logic [1:0] c);
    a_coins = c;
    @(negedge clk);
    a_coins = 2'b00;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({m_sell, m_sell_id, m_change, m_rej, m_deny, m_credit, m_state} !== '0) begin
      n_bad++; $display("FAIL reset_m: got sell=%b id=%0d chg=%b rej=%b deny=%b cr=%0d st=%0d expected all 0",
                        m_sell, m_sell_id, m_change, m_rej, m_deny, m_credit, m_state);
    end
    n_cmp++;
    if ({a_credit, a_state, a_sell} !== '0) begin
      n_bad++; $display("FAIL reset_a: got cr=%0d st=%0d sell=%b expected 0", a_credit, a_state, a_sell);
    end
  endtask

  task automatic test_auto_exact;
    int cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      drv_a(2'b01);
      n_cmp++;
      if (a_credit !== 6'(i) || a_state !== 3'd1) begin
        n_bad++; $display("FAIL auto_exact_acc%0d: got cr=%0d st=%0d expected cr=%0d st=1", i, a_credit, a_state, i);
      end
    end
    exp_a_q.push_back(0);
    drv_a(2'b01);
    n_cmp++;
    if (a_sell !== 1'b1 || a_state !== 3'd2 || a_credit !== 6'd0) begin
      n_bad++; $display("FAIL auto_exact_vend: got sell=%b st=%0d cr=%0d expected 1/2/0", a_sell, a_state, a_credit);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += int'(a_change);
    end
    n_cmp++;
    if (cnt !== 0 || a_state !== 3'd0 || a_sell !== 1'b0) begin
      n_bad++; $display("FAIL auto_exact_after: got chg=%0d st=%0d sell=%b expected 0/0/0", cnt, a_state, a_sell);
    end
  endtask

  task automatic test_auto_change;
    int cnt = 0;
    drv_a(2'b10);
    drv_a(2'b01);
    n_cmp++;
    if (a_credit !== 6'd3) begin
      n_bad++; $display("FAIL auto_change_acc: got cr=%0d expected 3", a_credit);
    end
    exp_a_q.push_back(0);
    drv_a(2'b10);
    n_cmp++;
    if (a_state !== 3'd2 || a_credit !== 6'd1) begin
      n_bad++; $display("FAIL auto_change_vend: got st=%0d cr=%0d expected 2/1", a_state, a_credit);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(a_change);
    end
    n_cmp++;
    if (cnt !== 1 || a_state !== 3'd0 || a_credit !== 6'd0) begin
      n_bad++; $display("FAIL auto_change_ret: got chg=%0d st=%0d cr=%0d expected 1/0/0", cnt, a_state, a_credit);
    end
  endtask

  task automatic test_select;
    drv_m(2'b10, 0, 0, 0);
    drv_m(2'b10, 0, 0, 0);
    drv_m(2'b00, 1, 2'd1, 0);
    n_cmp++;
    if (m_deny !== 1'b1 || m_credit !== 6'd4 || m_sell !== 1'b0) begin
      n_bad++; $display("FAIL select_deny: got deny=%b cr=%0d sell=%b expected 1/4/0", m_deny, m_credit, m_sell);
    end
    drv_m(2'b10, 0, 0, 0);
    exp_m_q.push_back(1);
    drv_m(2'b00, 1, 2'd1, 0);
    n_cmp++;
    if (m_sell !== 1'b1 || m_sell_id !== 2'd1 || m_credit !== 6'd0 || m_deny !== 1'b0) begin
      n_bad++; $display("FAIL select_vend: got sell=%b id=%0d cr=%0d deny=%b expected 1/1/0/0",
                        m_sell, m_sell_id, m_credit, m_deny);
    end
    @(negedge clk);
    n_cmp++;
    if (m_state !== 3'd0 || m_change !== 1'b0) begin
      n_bad++; $display("FAIL select_idle: got st=%0d chg=%b expected 0/0", m_state, m_change);
    end
  endtask

  task automatic test_cancel_empty;
    drv_m(2'b00, 0, 0, 1);
    n_cmp++;
    if (m_state !== 3'd0 || m_credit !== 6'd0 || m_change !== 1'b0) begin
      n_bad++; $display("FAIL cancel_empty: got st=%0d cr=%0d chg=%b expected 0/0/0", m_state, m_credit, m_change);
    end
  endtask

  task automatic test_refund;
    int cnt = 0;
    drv_m(2'b10, 0, 0, 0);
    drv_m(2'b01, 0, 0, 0);
    drv_m(2'b00, 0, 0, 1);
    n_cmp++;
    if (m_state !== 3'd3 || m_credit !== 6'd3) begin
      n_bad++; $display("FAIL refund_enter: got st=%0d cr=%0d expected 3/3", m_state, m_credit);
    end
    drv_m(2'b10, 0, 0, 0);
    cnt += int'(m_change);
    n_cmp++;
    if (m_rej !== 1'b1 || m_credit !== 6'd2) begin
      n_bad++; $display("FAIL refund_coin_rej: got rej=%b cr=%0d expected 1/2", m_rej, m_credit);
    end
    drv_m(2'b00, 1, 2'd0, 0);
    cnt += int'(m_change);
    n_cmp++;
    if (m_deny !== 1'b1 || m_sell !== 1'b0) begin
      n_bad++; $display("FAIL refund_sel_deny: got deny=%b sell=%b expected 1/0", m_deny, m_sell);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += int'(m_change);
    end
    n_cmp++;
    if (cnt !== 3 || m_state !== 3'd0 || m_credit !== 6'd0) begin
      n_bad++; $display("FAIL refund_count: got chg=%0d st=%0d cr=%0d expected 3/0/0", cnt, m_state, m_credit);
    end
  endtask

  task automatic test_overflow;
    int  cnt = 0;
    bool_done: begin end
    for (int i = 0; i < 9; i++) drv_m(2'b11, 0, 0, 0);
    drv_m(2'b10, 0, 0, 0);
    drv_m(2'b01, 0, 0, 0);
    n_cmp++;
    if (m_credit !== 6'd39) begin
      n_bad++; $display("FAIL ovf_fill: got cr=%0d expected 39", m_credit);
    end
    drv_m(2'b10, 0, 0, 0);
    n_cmp++;
    if (m_rej !== 1'b1 || m_credit !== 6'd39) begin
      n_bad++; $display("FAIL ovf_reject: got rej=%b cr=%0d expected 1/39", m_rej, m_credit);
    end
    drv_m(2'b01, 0, 0, 0);
    n_cmp++;
    if (m_rej !== 1'b0 || m_credit !== 6'd40) begin
      n_bad++; $display("FAIL ovf_max: got rej=%b cr=%0d expected 0/40", m_rej, m_credit);
    end
    drv_m(2'b11, 0, 0, 0);
    n_cmp++;
    if (m_rej !== 1'b1 || m_credit !== 6'd40) begin
      n_bad++; $display("FAIL ovf_full_reject: got rej=%b cr=%0d expected 1/40", m_rej, m_credit);
    end
    drv_m(2'b00, 0, 0, 1);
    begin
      bit idle = 1'b0;
      for (int i = 0; i < 60 && !idle; i++) begin
        @(negedge clk);
        cnt += int'(m_change);
        idle = (m_state === 3'd0);
      end
      n_cmp++;
      if (!idle || cnt !== 40) begin
        n_bad++; $display("FAIL ovf_drain: got chg=%0d idle=%b expected 40/1", cnt, idle);
      end
    end
    drv_m(2'b11, 0, 0, 0);
    drv_m(2'b11, 0, 0, 0);
    drv_m(2'b01, 0, 0, 0);
    n_cmp++;
    if (m_credit !== 6'd9) begin
      n_bad++; $display("FAIL ovf_nine: got cr=%0d expected 9", m_credit);
    end
    exp_m_q.push_back(3);
    drv_m(2'b01, 1, 2'd3, 0);
    n_cmp++;
    if (m_sell !== 1'b1 || m_credit !== 6'd0 || m_state !== 3'd2) begin
      n_bad++; $display("FAIL ovf_same_cycle_vend: got sell=%b cr=%0d st=%0d expected 1/0/2", m_sell, m_credit, m_state);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int cnt = 0;
    drv_m(2'b11, 0, 0, 0);
    drv_m(2'b01, 0, 0, 0);
    drv_m(2'b00, 0, 0, 1);
    @(negedge clk);
    n_cmp++;
    if (m_state !== 3'd3 || m_credit !== 6'd4 || m_change !== 1'b1) begin
      n_bad++; $display("FAIL areset_pre: got st=%0d cr=%0d chg=%b expected 3/4/1", m_state, m_credit, m_change);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({m_sell, m_sell_id, m_change, m_rej, m_deny, m_credit, m_state} !== '0) begin
      n_bad++; $display("FAIL areset_now: got sell=%b id=%0d chg=%b rej=%b deny=%b cr=%0d st=%0d expected all 0",
                        m_sell, m_sell_id, m_change, m_rej, m_deny, m_credit, m_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt += int'(m_change);
    end
    n_cmp++;
    if (cnt !== 0 || m_state !== 3'd0 || m_credit !== 6'd0) begin
      n_bad++; $display("FAIL areset_after: got chg=%0d st=%0d cr=%0d expected 0/0/0", cnt, m_state, m_credit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_auto_exact();
    test_auto_change();
    test_select();
    test_cancel_empty();
    test_refund();
    test_overflow();
    test_async_reset();
    n_cmp++;
    if (exp_m_q.size() != 0 || exp_a_q.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover: got %0d/%0d pending vends expected 0/0", exp_m_q.size(), exp_a_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
